// File: rtl/ps2_mouse_tracker_if.sv
// Byte stream from the PS/2 receiver into the cursor tracker.
interface ps2_mouse_tracker_if;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output rx_data, output rx_valid);
  modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse packet assembler and clamped cursor tracker.
// Frames 3-byte (or 4-byte IntelliMouse) stream packets, scales the 9-bit
// deltas and applies them to X/Y registers clamped to the screen area.
module ps2_mouse_tracker #(
  parameter int X_W         = 10,
  parameter int Y_W         = 10,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int X_INIT      = 320,
  parameter int Y_INIT      = 240,
  parameter int WHEEL_EN    = 0,
  parameter int SHIFT       = 0,
  parameter int Y_INVERT    = 1,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                 CLK,
  input  logic                 RST,
  ps2_mouse_tracker_if.slave   rx,
  output logic [X_W-1:0]       x_pos,
  output logic [Y_W-1:0]       y_pos,
  output logic [2:0]           buttons,
  output logic [3:0]           wheel,
  output logic                 packet_valid,
  output logic                 sync_err,
  output logic [1:0]           ovf
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {B0, B1, B2, B3} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   tcnt;
  logic [7:0]      b0_q, dx_q, dy_q;
  logic            apply, drop, tmo;
  logic [7:0]      dy_byte;
  logic signed [8:0] dx, dy, dx_s, dy_s;
  int              xn, yn;
  logic [X_W-1:0]  x_nx;
  logic [Y_W-1:0]  y_nx;

  // State register and in-packet idle counter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= B0;
      tcnt  <= '0;
    end else begin
      state <= state_nx;
      if (state == B0 || rx.rx_valid || tmo)
        tcnt <= '0;
      else
        tcnt <= tcnt + CW'(1);
    end
  end

  // Next-state: advance one byte per strobe, abandon on idle timeout
  always_comb begin
    state_nx = state;
    if (rx.rx_valid) begin
      unique case (state)
        B0: state_nx = rx.rx_data[3] ? B1 : B0;
        B1: state_nx = B2;
        B2: state_nx = (WHEEL_EN != 0) ? B3 : B0;
        B3: state_nx = B0;
      endcase
    end else if (tmo) begin
      state_nx = B0;
    end
  end

  // Strobes and delta arithmetic for the packet being completed
  always_comb begin
    drop  = (state == B0) && rx.rx_valid && !rx.rx_data[3];
    apply = rx.rx_valid && (((state == B2) && (WHEEL_EN == 0)) || (state == B3));
    tmo   = (state != B0) && !rx.rx_valid && (tcnt == CW'(TIMEOUT_CYC - 1));
    // In 3-byte mode the dy byte is still on the bus when the packet applies.
    dy_byte = (state == B3) ? dy_q : rx.rx_data;
    dx   = b0_q[6] ? '0 : {b0_q[4], dx_q};
    dy   = b0_q[7] ? '0 : {b0_q[5], dy_byte};
    dx_s = dx >>> SHIFT;
    dy_s = dy >>> SHIFT;
    xn   = int'(x_pos) + int'(dx_s);
    yn   = (Y_INVERT != 0) ? int'(y_pos) - int'(dy_s) : int'(y_pos) + int'(dy_s);
    if (xn < 0)          x_nx = '0;
    else if (xn > X_MAX) x_nx = X_W'(X_MAX);
    else                 x_nx = X_W'(xn);
    if (yn < 0)          y_nx = '0;
    else if (yn > Y_MAX) y_nx = Y_W'(Y_MAX);
    else                 y_nx = Y_W'(yn);
  end

  // Byte capture and published cursor state
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      b0_q         <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      x_pos        <= X_W'(X_INIT);
      y_pos        <= Y_W'(Y_INIT);
      buttons      <= '0;
      wheel        <= '0;
      ovf          <= '0;
      packet_valid <= 1'b0;
      sync_err     <= 1'b0;
    end else begin
      packet_valid <= apply;
      sync_err     <= drop | tmo;
      if (rx.rx_valid) begin
        unique case (state)
          B0: if (rx.rx_data[3]) b0_q <= rx.rx_data;
          B1: dx_q <= rx.rx_data;
          B2: dy_q <= rx.rx_data;
          B3: ;
        endcase
      end
      if (apply) begin
        x_pos   <= x_nx;
        y_pos   <= y_nx;
        buttons <= b0_q[2:0];
        ovf     <= {b0_q[7], b0_q[6]};
        wheel   <= (WHEEL_EN != 0) ? rx.rx_data[3:0] : '0;
      end
    end
  end

endmodule
